// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED sequencer: display modes, LED register
// addresses and the scroll rotate helper.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  localparam logic [1:0] LED_ADDR_LO = 2'b00;
  localparam logic [1:0] LED_ADDR_HI = 2'b10;

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-tick prescaler: tick is high while the counter sits at TICK_DIV-1,
// and clr restarts the count so the next tick lands TICK_DIV cycles later.
module led_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic led_clk,
  input  logic ledrst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      r_cnt <= '0;
    end else if (clr || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// LED write scheduler: keeps the shadow LED byte and issues one-cycle write
// strobes to the LED register according to the PASS/BLINK/SCROLL/FREEZE mode.
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic        led_clk,
  input  logic        ledrst_n,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  mode,
  output logic        ledcs,
  output logic        ledwrite,
  output logic [1:0]  ledaddr,
  output logic [15:0] ledwdata,
  output logic [1:0]  mode_q
);

  mode_e      r_mode_q;
  logic [7:0] r_shadow;
  logic [7:0] r_scroll;
  logic       r_phase;
  logic       r_ledcs;
  logic [1:0] r_ledaddr;
  logic [7:0] r_ledwdata;

  mode_e      w_mode;
  logic       w_acc;
  logic [7:0] w_byte;
  logic [7:0] w_shadow_new;
  logic       w_chg;
  logic       w_tick;

  assign w_mode       = mode_e'(mode);
  assign w_acc        = cpu_req && (cpu_addr == LED_ADDR_LO || cpu_addr == LED_ADDR_HI);
  assign w_byte       = (cpu_addr == LED_ADDR_HI) ? cpu_wdata[15:8] : cpu_wdata[7:0];
  assign w_shadow_new = w_acc ? w_byte : r_shadow;
  assign w_chg        = (w_mode != r_mode_q);

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .led_clk (led_clk),
    .ledrst_n(ledrst_n),
    .clr     (w_chg),
    .tick    (w_tick)
  );

  // A mode change re-initialises the pattern, so a coincident tick is dropped.
  // In SCROLL a CPU reload beats a same-cycle tick: no rotation that cycle.
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      r_mode_q   <= MODE_PASS;
      r_shadow   <= 8'h00;
      r_scroll   <= 8'h00;
      r_phase    <= 1'b1;
      r_ledcs    <= 1'b0;
      r_ledaddr  <= LED_ADDR_LO;
      r_ledwdata <= 8'h00;
    end else begin
      r_ledcs   <= 1'b0;
      r_ledaddr <= LED_ADDR_LO;
      r_shadow  <= w_shadow_new;
      if (w_chg) begin
        r_mode_q <= w_mode;
        r_phase  <= 1'b1;
        r_scroll <= w_shadow_new;
        if (w_mode != MODE_FREEZE) begin
          r_ledcs    <= 1'b1;
          r_ledwdata <= w_shadow_new;
        end
      end else begin
        case (r_mode_q)
          MODE_PASS: begin
            if (w_acc) begin
              r_ledcs    <= 1'b1;
              r_ledwdata <= w_byte;
            end
          end
          MODE_BLINK: begin
            if (w_tick) begin
              r_phase    <= ~r_phase;
              r_ledcs    <= 1'b1;
              r_ledwdata <= r_phase ? 8'h00 : w_shadow_new;
            end
          end
          MODE_SCROLL: begin
            if (w_acc) begin
              r_scroll   <= w_byte;
              r_ledcs    <= 1'b1;
              r_ledwdata <= w_byte;
            end else if (w_tick) begin
              r_scroll   <= rotl8(r_scroll);
              r_ledcs    <= 1'b1;
              r_ledwdata <= rotl8(r_scroll);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ledcs    = r_ledcs;
  assign ledwrite = r_ledcs;
  assign ledaddr  = r_ledaddr;
  assign ledwdata = {8'h00, r_ledwdata};
  assign mode_q   = r_mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed vector table, randomized run against a
// behavioural model, and an asynchronous reset during BLINK.
module tb_led_seq_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [1:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [1:0]  mode;
  logic        ledcs;
  logic        ledwrite;
  logic [1:0]  ledaddr;
  logic [15:0] ledwdata;
  logic [1:0]  mode_q;

  int checks = 0;
  int errors = 0;

  led_seq_ctrl #(.TICK_DIV(TD)) dut (
    .led_clk  (clk),
    .ledrst_n (rst_n),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .mode     (mode),
    .ledcs    (ledcs),
    .ledwrite (ledwrite),
    .ledaddr  (ledaddr),
    .ledwdata (ledwdata),
    .mode_q   (mode_q)
  );

  always #5 clk = ~clk;

  // Reference model: mode, shadow byte, scroll byte, blink phase and the
  // number of cycles elapsed since the last mode change or reset.
  int m_mode, m_shadow, m_scroll, m_on, m_age, m_cs, m_data;

  task automatic model_reset();
    m_mode = 0; m_shadow = 0; m_scroll = 0; m_on = 1; m_age = 0; m_cs = 0; m_data = 0;
  endtask

  task automatic model_step(input int req, input int addr, input int wdata, input int md);
    int acc, byte_v, tick;
    acc    = (req != 0) && (addr == 0 || addr == 2);
    byte_v = (addr == 2) ? (wdata / 256) % 256 : wdata % 256;
    tick   = ((m_age % TD) == TD - 1);
    m_cs   = 0;
    if (md != m_mode) begin
      if (acc) m_shadow = byte_v;
      m_mode   = md;
      m_on     = 1;
      m_scroll = m_shadow;
      m_age    = 0;
      if (md != 3) begin m_cs = 1; m_data = m_shadow; end
    end else begin
      m_age = m_age + 1;
      if (acc) m_shadow = byte_v;
      if (md == 0 && acc) begin
        m_cs = 1; m_data = byte_v;
      end else if (md == 1 && tick) begin
        m_on = 1 - m_on; m_cs = 1; m_data = m_on ? m_shadow : 0;
      end else if (md == 2 && acc) begin
        m_scroll = byte_v; m_cs = 1; m_data = byte_v;
      end else if (md == 2 && tick) begin
        m_scroll = (m_scroll * 2) % 256 + m_scroll / 128;
        m_cs = 1; m_data = m_scroll;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after an edge, advance one edge, settle 1 time unit.
  task automatic drive_step(input logic req, input logic [1:0] addr, input logic [15:0] wdata,
                            input logic [1:0] md);
    cpu_req = req; cpu_addr = addr; cpu_wdata = wdata; mode = md;
    model_step(int'(req), int'(addr), int'(wdata), int'(md));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  md;
    logic        cs;
    logic [15:0] data;
    logic [1:0]  mq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic [1:0] addr, input logic [15:0] wdata,
                     input logic [1:0] md, input logic cs, input logic [15:0] data,
                     input logic [1:0] mq);
    vec_t v;
    v.req = req; v.addr = addr; v.wdata = wdata; v.md = md;
    v.cs = cs; v.data = data; v.mq = mq;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input logic [1:0] md, input logic [15:0] data);
    for (int k = 0; k < n; k++) add(1'b0, 2'd0, 16'h0000, md, 1'b0, data, md);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = 2'd0; cpu_wdata = 16'h0; mode = 2'd0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_cs", int'(ledcs), 0);
    chk("reset_we", int'(ledwrite), 0);
    chk("reset_addr", int'(ledaddr), 0);
    chk("reset_data", int'(ledwdata), 0);
    chk("reset_modeq", int'(mode_q), 0);
    rst_n = 1'b1;

    // PASS byte select, ignored address, shadow retained across FREEZE/PASS
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    add(1, 0, 16'h12A5, 0, 1, 16'h00A5, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h00A5, 0);
    add(1, 2, 16'h12A5, 0, 1, 16'h0012, 0);
    add(1, 1, 16'hFFFF, 0, 0, 16'h0012, 0);
    add(0, 0, 16'h0000, 3, 0, 16'h0012, 3);
    add(0, 0, 16'h0000, 0, 1, 16'h0012, 0);
    // SCROLL from 81
    add(1, 0, 16'h0081, 0, 1, 16'h0081, 0);
    add(0, 0, 16'h0000, 2, 1, 16'h0081, 2);
    idle(3, 2, 16'h0081); add(0, 0, 16'h0000, 2, 1, 16'h0003, 2);
    idle(3, 2, 16'h0003); add(0, 0, 16'h0000, 2, 1, 16'h0006, 2);
    idle(3, 2, 16'h0006); add(0, 0, 16'h0000, 2, 1, 16'h000C, 2);
    // BLINK with F0, CPU write 0F while OFF
    add(0, 0, 16'h0000, 3, 0, 16'h000C, 3);
    add(1, 0, 16'h00F0, 3, 0, 16'h000C, 3);
    add(0, 0, 16'h0000, 1, 1, 16'h00F0, 1);
    idle(3, 1, 16'h00F0); add(0, 0, 16'h0000, 1, 1, 16'h0000, 1);
    add(1, 0, 16'h000F, 1, 0, 16'h0000, 1);
    idle(2, 1, 16'h0000); add(0, 0, 16'h0000, 1, 1, 16'h000F, 1);
    idle(3, 1, 16'h000F); add(0, 0, 16'h0000, 1, 1, 16'h0000, 1);
    // FREEZE for 20 cycles with CPU writes, then PASS refresh
    add(0, 0, 16'h0000, 3, 0, 16'h0000, 3);
    for (int k = 0; k < 20; k++) add(1, 0, 16'h0055, 3, 0, 16'h0000, 3);
    add(0, 0, 16'h0000, 0, 1, 16'h0055, 0);
    // Mode change + CPU write together, then tick + CPU write together
    add(1, 0, 16'h003C, 2, 1, 16'h003C, 2);
    idle(3, 2, 16'h003C); add(1, 0, 16'h0077, 2, 1, 16'h0077, 2);
    idle(3, 2, 16'h0077); add(0, 0, 16'h0000, 2, 1, 16'h00EE, 2);

    foreach (vecs[i]) begin
      drive_step(vecs[i].req, vecs[i].addr, vecs[i].wdata, vecs[i].md);
      $display("vec %0d req=%0d addr=%0d wdata=%h mode=%0d -> cs=%0d data=%h mode_q=%0d",
               i, vecs[i].req, vecs[i].addr, vecs[i].wdata, vecs[i].md, ledcs, ledwdata, mode_q);
      chk($sformatf("vec%0d_cs", i), int'(ledcs), int'(vecs[i].cs));
      chk($sformatf("vec%0d_we", i), int'(ledwrite), int'(vecs[i].cs));
      chk($sformatf("vec%0d_addr", i), int'(ledaddr), 0);
      chk($sformatf("vec%0d_data", i), int'(ledwdata), int'(vecs[i].data));
      chk($sformatf("vec%0d_modeq", i), int'(mode_q), int'(vecs[i].mq));
    end

    // Randomized run against the model
    begin
      logic [1:0] cur_mode;
      logic       r_req;
      logic [1:0] r_addr;
      logic [15:0] r_wd;
      cur_mode = mode;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 99) < 6) cur_mode = 2'($urandom_range(0, 3));
        r_req  = ($urandom_range(0, 99) < 35);
        r_addr = 2'($urandom_range(0, 3));
        r_wd   = 16'($urandom);
        drive_step(r_req, r_addr, r_wd, cur_mode);
        if (ledcs) $display("rnd %0d mode=%0d req=%0d addr=%0d wdata=%h -> data=%h",
                            n, cur_mode, r_req, r_addr, r_wd, ledwdata);
        chk("rnd_cs", int'(ledcs), m_cs);
        chk("rnd_we", int'(ledwrite), m_cs);
        chk("rnd_addr", int'(ledaddr), 0);
        chk("rnd_data", int'(ledwdata), m_data);
        chk("rnd_modeq", int'(mode_q), m_mode);
      end
    end

    // Asynchronous reset while a BLINK refresh strobe is on the outputs
    drive_step(1, 0, 16'h00A7, 3);
    drive_step(0, 0, 16'h0000, 1);
    chk("blink_refresh_cs", int'(ledcs), 1);
    chk("blink_refresh_data", int'(ledwdata), 16'h00A7);
    #2;
    rst_n = 1'b0;
    mode  = 2'd0;
    #1;
    chk("async_rst_cs", int'(ledcs), 0);
    chk("async_rst_we", int'(ledwrite), 0);
    chk("async_rst_data", int'(ledwdata), 0);
    chk("async_rst_modeq", int'(mode_q), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      drive_step(0, 0, 16'h0000, 0);
      chk("post_rst_idle_cs", int'(ledcs), 0);
    end
    drive_step(1, 0, 16'h00C3, 0);
    $display("post-reset write wdata=00C3 -> cs=%0d data=%h", ledcs, ledwdata);
    chk("post_rst_write_cs", int'(ledcs), 1);
    chk("post_rst_write_data", int'(ledwdata), 16'h00C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencer and write scheduler for the 8-bit board LED output register. Sits between the memorio LED path and the LED output register. It accepts CPU LED writes, keeps a shadow of the intended LED byte, and schedules single-cycle write strobes to the LED register according to a display mode: pass-through, blink, scroll or freeze. It is the only driver of the LED register's chip-select, write-enable, address and data inputs.

## Interface
- `TICK_DIV`, default 1_000_000: `led_clk` cycles per pattern tick; must be ≥ 2. Benches use 4.
- `led_clk` in 1: single clock for the whole block (cpu_clk domain).
- `ledrst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: one-cycle CPU LED write strobe from memorio (LEDCtrl AND write).
- `cpu_addr` in 2: 2'b00 selects low byte of `cpu_wdata`, 2'b10 selects high byte; other codes are ignored (no shadow change, no write).
- `cpu_wdata` in 16: CPU write data.
- `mode` in 2: display mode from switches; 00 PASS, 01 BLINK, 10 SCROLL, 11 FREEZE. Sampled every cycle.
- `ledcs` out 1: LED chip-select to the LED register.
- `ledwrite` out 1: LED write enable; always equals `ledcs`.
- `ledaddr` out 2: always 2'b00.
- `ledwdata` out 16: {8'h00, display byte}.
- `mode_q` out 2: currently active (registered) mode.

## Operation
- Shadow byte `shadow[7:0]` is loaded on an accepted CPU write (`cpu_req` with a valid `cpu_addr`) in every mode, using the selected byte.
- `mode_q` is registered from `mode`. A mode change is a cycle where `mode` != `mode_q`.
- On a mode change:
  - The tick counter clears.
  - BLINK phase is set to ON.
  - The scroll register loads the shadow value. If a CPU write is accepted in the same cycle, the new shadow value is used.
  - One refresh write is issued unless the new mode is FREEZE:
    - PASS and BLINK write the shadow.
    - SCROLL writes the scroll register.
- PASS: each accepted CPU write produces one LED write of the new byte. Ticks are ignored.
- BLINK:
  - At each tick the phase toggles.
  - Then an LED write is issued: shadow if ON, 8'h00 if OFF.
  - A CPU write updates the shadow only; it becomes visible at the next ON write.
- SCROLL:
  - At each tick the scroll register rotates left by 1 (bit7 goes to bit0) and an LED write of the rotated value is issued.
  - A CPU write reloads the scroll register with the new byte and issues an LED write of it immediately.
  - A value of 8'h00 rotates to 8'h00; the write is still issued.
- FREEZE: no LED writes. The shadow still tracks CPU writes.
- Arbitration: at most one LED write per cycle. Priority is mode-change refresh, then CPU write, then tick. A lower-priority event in the same cycle is not queued; its state effects still apply.
- Reset (async assert, any time): all outputs 0, `mode_q`=00, shadow=0, scroll register=0, phase ON, tick counter 0.
  - A write in flight is dropped.
  - After reset release the block is in PASS with no refresh write, because the reset `mode_q` is 00 and a mode change is only detected if `mode` != 00.

## Timing
- `ledcs`, `ledwrite`, `ledaddr` and `ledwdata` are registered.
- Latency is 1 cycle: event at edge N → write strobe high in cycle N+1 for exactly one cycle.
- `ledwdata` holds its last value when no strobe is active.
- Tick counter counts 0..TICK_DIV-1. The tick fires in the cycle the counter equals TICK_DIV-1, then wraps to 0. The first tick after a mode change occurs TICK_DIV cycles later.
- Back-to-back CPU writes in PASS produce back-to-back strobes; the last value wins.
- `mode_q` updates one cycle after `mode` changes; the refresh strobe appears in the same cycle as the new `mode_q`.

## Structure
- Package `led_ctrl_pkg`:
  - Mode encodings: MODE_PASS, MODE_BLINK, MODE_SCROLL, MODE_FREEZE.
  - LED address constants: LED_ADDR_LO=2'b00, LED_ADDR_HI=2'b10.
- Sub-module `led_tick_gen` (prescaler):
  - Inputs: `led_clk`, `ledrst_n`, `clr`.
  - Output: `tick`.
  - Parameter: `TICK_DIV`.
  - Counter width is $clog2(TICK_DIV).
- Top contains the mode register, shadow, scroll and phase registers, and the output write scheduler.

## Test plan
- Reset, then PASS, then `cpu_req` with addr=00, wdata=16'h12A5 → strobe 1 cycle later, `ledwdata`=16'h00A5. Repeat with addr=10 → `ledwdata`=16'h0012. Then addr=01 → no strobe and shadow unchanged.
- Shadow=8'h81, switch to SCROLL (TICK_DIV=4) → refresh write of 8'h81, then writes of 8'h03, 8'h06 and 8'h0C, spaced 4 cycles apart.
- BLINK with shadow=8'hF0 → refresh write of F0, then at successive ticks writes of 00, F0, 00. A CPU write of 8'h0F while OFF → no strobe, and the next ON write is 0F.
- FREEZE → no strobes for 20 cycles while CPU writes 8'h55. Then switch to PASS → single refresh write of 8'h55.
- Same-cycle mode change (PASS→SCROLL) plus CPU write of 8'h3C → exactly one strobe of 3C. A tick coinciding with a CPU write in SCROLL → one strobe carrying the CPU value.
- Assert `ledrst_n` low mid-BLINK while a strobe is pending → all outputs 0 immediately and `mode_q`=00. After release with `mode`=00 → no strobes until a CPU write.
